// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift-count width helper.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_CLR   = 3'b110;
    // 111 is a second clear code; both decode identically.
    localparam logic [2:0] MODE_CLR_2 = 3'b111;

    // Bits needed to hold a count of 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating count of shifts since the last load/clear, with a one-cycle
// word_done pulse on the shift that fills a whole word.
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] shift_cnt,
    output logic          word_done
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else if (!en) begin
            word_done <= 1'b0;
        end else if (clr) begin
            // Load/clear always wins over whatever the counter holds.
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else if (inc && shift_cnt != CNT_MAX) begin
            shift_cnt <= shift_cnt + 1'b1;
            word_done <= (shift_cnt == CNT_LAST);
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, parallel load, clear.
// Rotate codes 100/101 exist only when USR_ROTATE_EN is defined; otherwise they hold.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [2:0]                  mode,
    input  logic                        sin_msb,
    input  logic                        sin_lsb,
    input  logic [WIDTH-1:0]            par_in,
    output logic [WIDTH-1:0]            q,
    output logic                        sout_lsb,
    output logic                        sout_msb,
    output logic [cnt_width(WIDTH)-1:0] shift_cnt,
    output logic                        word_done
);

    logic [WIDTH-1:0] q_next;
    logic             inc;
    logic             clr;

    // NOTE: every always_comb output gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        q_next = q;
        inc    = 1'b0;
        clr    = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_next = {sin_msb, q[WIDTH-1:1]};
                inc    = 1'b1;
            end
            MODE_SHL: begin
                q_next = {q[WIDTH-2:0], sin_lsb};
                inc    = 1'b1;
            end
            MODE_LOAD: begin
                q_next = par_in;
                clr    = 1'b1;
            end
`ifdef USR_ROTATE_EN
            MODE_ROR: begin
                q_next = {q[0], q[WIDTH-1:1]};
                inc    = 1'b1;
            end
            MODE_ROL: begin
                q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                inc    = 1'b1;
            end
`endif
            MODE_CLR, MODE_CLR_2: begin
                q_next = '0;
                clr    = 1'b1;
            end
            default: begin
                // MODE_HOLD, and the rotate codes when rotation is not built.
                q_next = q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .inc       (inc),
        .clr       (clr),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, value loaded into q on reset; WIDTH bits.
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk externally.
REQ-005 en  input  1  operation enable; 0 forces hold regardless of mode.
REQ-006 mode  input  3  operation select, encoding per REQ-012.
REQ-007 sin_msb  input  1  serial data entering bit WIDTH-1 on shift-right.
REQ-008 sin_lsb  input  1  serial data entering bit 0 on shift-left.
REQ-009 par_in  input  WIDTH  parallel load data.
REQ-010 q  output  WIDTH  register contents (registered); sout_lsb = q[0], sout_msb = q[WIDTH-1] as separate 1-bit outputs.
REQ-011 shift_cnt  output  $clog2(WIDTH+1)  shifts since last load/clear (registered); word_done  output  1  one-cycle pulse (registered).

Function
REQ-012 Mode encoding, applied on rising clk when en=1:
- 000 hold.
- 001 shift right: q <= {sin_msb, q[WIDTH-1:1]}.
- 010 shift left: q <= {q[WIDTH-2:0], sin_lsb}.
- 011 parallel load: q <= par_in.
- 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
- 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 110, 111 synchronous clear: q <= 0.
REQ-013 Latency one cycle: q reflects an operation on the edge it is sampled; no combinational path from inputs to q, shift_cnt or word_done.
REQ-014 en=0 SHALL hold q and shift_cnt and drive word_done=0.
REQ-015 shift_cnt: load or clear sets 0; every executed shift or rotate increments by 1; saturates at WIDTH; hold leaves it unchanged.
REQ-016 word_done SHALL be 1 for exactly the cycle after the shift that moves shift_cnt from WIDTH-1 to WIDTH; no further pulse until shift_cnt is reset by load/clear.
REQ-017 Load on the same edge as count reaching WIDTH is impossible (single mode); load always wins over the counter state.
REQ-018 Undefined mode bits (X) need no defined behaviour; all legal codes fully decoded.

Reset
REQ-019 reset=0 SHALL immediately force q=RESET_VAL, shift_cnt=0, word_done=0, independent of clk.
REQ-020 Reset asserted mid-shift sequence aborts it; first edge after release executes mode normally with shift_cnt starting at 0.

Configuration
REQ-021 Macro USR_ROTATE_EN: when defined, codes 100/101 rotate per REQ-012; when undefined, codes 100/101 behave as hold (q and shift_cnt unchanged, no word_done) and rotate logic is not synthesised.

Structure
REQ-022 Package usr_pkg SHALL hold the mode encoding constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_CLR) and the count-width function.
REQ-023 Sub-module usr_shift_counter SHALL implement shift_cnt/word_done (inputs: inc, clr, en; parameter WIDTH); data path stays in univ_shift_reg.

Verification
REQ-024 WIDTH=4; reset low -> q=0000, shift_cnt=0, word_done=0 without clk edge.
REQ-025 Load par_in=1011, then 4 shift-right with sin_msb=0 -> q 0101,0010,0001,0000; sout_lsb sequence 1,1,0,1; word_done high exactly one cycle after 4th shift.
REQ-026 Load 0001, 2 shift-left sin_lsb=1 -> q 0011, 0111; shift_cnt=2; then en=0 for 3 cycles -> q and shift_cnt unchanged.
REQ-027 With USR_ROTATE_EN: load 1000, 4 rotate-left -> q 0001,0010,0100,1000, word_done pulse once; without macro same stimulus -> q stays 1000, shift_cnt=0.
REQ-028 Load 1111, 2 shifts, assert reset between edges -> q=RESET_VAL at once; after release, mode 110 -> q=0000, shift_cnt=0; 6 further shifts -> shift_cnt saturates at 4, single word_done.
